iter_div: RTL and testbench

ITER_DIV -- requirements
Module: iter_div

---
 rtl/mips_alu_pkg.sv | 14 +
 rtl/div_step.sv | 26 ++
 rtl/iter_div.sv | 144 ++++++++++++++
 tb/tb_iter_div.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// quotient value reported for a zero divisor.
package mips_alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Wide enough for the largest legal WIDTH; users slice the low bits.
   localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift out a quotient bit.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] work_in,
   input  logic [WIDTH-1:0] dsr,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] work_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           borrow;

   // rem_in < dsr always holds, so a non-borrowing difference fits in WIDTH bits.
   always_comb begin
      shifted  = {rem_in, work_in[WIDTH-1]};
      diff     = shifted - {1'b0, dsr};
      borrow   = diff[WIDTH];
      rem_out  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      work_out = {work_in[WIDTH-2:0], ~borrow};
   end

endmodule

// File: rtl/iter_div.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per cycle.
// Define ITER_DIV_REM_EN to drive the remainder output; otherwise it is tied to 0.
module iter_div
   import mips_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                   input logic             neg);
      return neg ? (~mag + WIDTH'(1)) : mag;
   endfunction

   div_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             neg_q;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] part_rem;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_work;
   logic [WIDTH-1:0] q_out;
   logic             dz_out;

   logic             accept;
   logic             last_step;
   logic             dvd_neg;
   logic             dsr_neg;
   logic             dsr_zero;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dsr_mag;

   always_comb begin
      accept    = in_valid && (state == IDLE);
      last_step = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
      dvd_neg   = signed_op && dividend[WIDTH-1];
      dsr_neg   = signed_op && divisor[WIDTH-1];
      dsr_zero  = (divisor == '0);
      dvd_mag   = apply_sign(dividend, dvd_neg);
      dsr_mag   = apply_sign(divisor, dsr_neg);
   end

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_in  (part_rem),
      .work_in (work),
      .dsr     (dsr),
      .rem_out (step_rem),
      .work_out(step_work)
   );

   always_ff @(posedge clk1) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = dsr_zero ? DONE : RUN;
         end
         RUN: begin
            if (last_step) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Working registers: operands are captured only on acceptance, so input
   // changes during RUN/DONE cannot disturb an in-flight divide.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         cnt      <= '0;
         neg_q    <= 1'b0;
         work     <= '0;
         dsr      <= '0;
         part_rem <= '0;
         q_out    <= '0;
         dz_out   <= 1'b0;
      end else if (accept) begin
         cnt      <= '0;
         neg_q    <= dvd_neg ^ dsr_neg;
         work     <= dvd_mag;
         dsr      <= dsr_mag;
         part_rem <= '0;
         dz_out   <= dsr_zero;
         if (dsr_zero) q_out <= DIV0_QUOT[WIDTH-1:0];
      end else if (state == RUN) begin
         cnt      <= cnt + CNT_W'(1);
         work     <= step_work;
         part_rem <= step_rem;
         if (last_step) q_out <= apply_sign(step_work, neg_q);
      end
   end

`ifdef ITER_DIV_REM_EN
   logic             neg_r;
   logic [WIDTH-1:0] r_out;

   // Remainder takes the dividend's sign; a zero divisor passes the raw dividend.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         neg_r <= 1'b0;
         r_out <= '0;
      end else if (accept) begin
         neg_r <= dvd_neg;
         if (dsr_zero) r_out <= dividend;
      end else if (last_step) begin
         r_out <= apply_sign(step_rem, neg_r);
      end
   end

   assign remainder = r_out;
`else
   assign remainder = '0;
`endif

   assign quotient = q_out;
   assign div_zero = dz_out;

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div (WIDTH=32): hand-computed quotient/remainder,
// latency, hold-in-DONE and mid-run reset behaviour.
module tb_iter_div;

   localparam int W = 32;

   logic          clk1 = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          signed_op = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_zero;

   int n_cmp = 0;
   int n_bad = 0;

   iter_div #(.WIDTH(W)) dut (
      .clk1     (clk1),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .signed_op(signed_op),
      .dividend (dividend),
      .divisor  (divisor),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .quotient (quotient),
      .remainder(remainder),
      .div_zero (div_zero)
   );

   always #5 clk1 = ~clk1;

   function automatic logic [W-1:0] exp_rem(input logic [W-1:0] r);
`ifdef ITER_DIV_REM_EN
      return r;
`else
      return '0;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // lat = number of the edge after acceptance (edge E) at which out_valid is
   // first seen high by the consumer: WIDTH+1 normally, 1 for a zero divisor.
   task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input logic ez, input int lat,
                         input bit consume);
      int n;
      @(negedge clk1);
      check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
      signed_op = s;
      dividend  = a;
      divisor   = b;
      in_valid  = 1'b1;
      @(posedge clk1);
      #1;
      in_valid  = 1'b0;
      signed_op = ~s;
      dividend  = ~a;
      divisor   = b ^ 32'h0000_5a5a;
      n = 0;
      while (n < 100) begin
         @(negedge clk1);
         n++;
         if (out_valid) break;
      end
      check({tag, "_lat"}, 64'(n), 64'(lat));
      check({tag, "_q"}, 64'(quotient), 64'(eq));
      check({tag, "_r"}, 64'(remainder), 64'(exp_rem(er)));
      check({tag, "_dz"}, {63'd0, div_zero}, {63'd0, ez});
      if (consume) begin
         out_ready = 1'b1;
         @(posedge clk1);
         #1;
         out_ready = 1'b0;
         check({tag, "_idle"}, {62'd0, out_valid, in_ready}, 64'b01);
      end
   endtask

   initial begin
      int seen;

      repeat (3) @(posedge clk1);
      #1;
      check("rst_ready", {63'd0, in_ready}, 64'd1);
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check("rst_q", 64'(quotient), 64'd0);
      check("rst_r", 64'(remainder), 64'd0);
      check("rst_dz", {63'd0, div_zero}, 64'd0);
      @(negedge clk1);
      rst_n = 1'b1;

      run_op("u20_4",   1'b0, 32'd20,        32'd4,          32'd5,          32'd0,          1'b0, W + 1, 1'b1);
      run_op("sm20_3",  1'b1, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFA,  32'hFFFF_FFFE,  1'b0, W + 1, 1'b1);
      run_op("s20_m3",  1'b1, 32'd20,        32'hFFFF_FFFD,  32'hFFFF_FFFA,  32'd2,          1'b0, W + 1, 1'b1);
      run_op("sm7_m2",  1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, W + 1, 1'b1);
      run_op("u7_0",    1'b0, 32'd7,         32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1, 1,     1'b1);
      run_op("s7_0",    1'b1, 32'd7,         32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1, 1,     1'b1);
      run_op("smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, W + 1, 1'b1);
      run_op("umin_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, W + 1, 1'b1);
      run_op("umax_1",  1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, W + 1, 1'b1);

      // Result held for 10 cycles with a competing request on the inputs.
      run_op("hold", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, W + 1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk1);
         in_valid  = 1'b1;
         signed_op = 1'b1;
         dividend  = 32'(i * 77 + 5);
         divisor   = 32'(i);
         @(posedge clk1);
         #1;
         check("hold_q", 64'(quotient), 64'd30);
         check("hold_r", 64'(remainder), 64'(exp_rem(32'd10)));
         check("hold_st", {61'd0, div_zero, out_valid, in_ready}, 64'b010);
      end
      @(negedge clk1);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk1);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("hold_release", {62'd0, out_valid, in_ready}, 64'b01);
      @(posedge clk1);
      #1;
      check("hold_noaccept", {62'd0, out_valid, in_ready}, 64'b01);

      // Reset during RUN cycle 10 discards the operation.
      @(negedge clk1);
      signed_op = 1'b0;
      dividend  = 32'd123456;
      divisor   = 32'd789;
      in_valid  = 1'b1;
      @(posedge clk1);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk1);
      @(negedge clk1);
      rst_n = 1'b0;
      @(posedge clk1);
      #1;
      check("abort_st", {62'd0, out_valid, in_ready}, 64'b01);
      check("abort_q", 64'(quotient), 64'd0);
      check("abort_r", 64'(remainder), 64'd0);
      check("abort_dz", {63'd0, div_zero}, 64'd0);
      @(negedge clk1);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk1);
         if (out_valid) seen++;
      end
      check("abort_noresult", 64'(seen), 64'd0);
      run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W + 1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
